md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the execute stage of the pipelined MIPS core.
- Consumes the two forwarded register-file read operands and holds the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, plus MTHI/MTLO writes and MFHI/MFLO reads.
- Exports busy so the hazard unit can stall dependent md instructions.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (must be >= 1)
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  issue strobe; md_op is sampled on a clk edge where start=1
- md_op  in  3  operation: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO
- a  in  32  operand rs (dividend, multiplicand, or MTHI/MTLO data)
- b  in  32  operand rt (divisor, multiplier)
- rd_hi  in  1  read select: 1 = HI, 0 = LO
- busy  out  1  high while a mult/div is in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- md_out  out  32  combinational read value: rd_hi ? hi : lo (MFHI/MFLO)

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset overrides every other input, including an in-flight operation: that operation is abandoned and never commits.
- Issue (start=1, busy=0) at edge N:
  - For MULT/MULTU/DIV/DIVU: capture the result into pending registers and load counter with MULT_CYCLES or DIV_CYCLES. busy is 1 from after edge N for exactly L cycles.
  - At edge N+L: counter reaches 0, hi/lo <= pending, busy <= 0. New hi/lo are visible in the same cycle busy is first low.
- While busy: hi/lo/md_out keep their old values. start is ignored for every op, including MTHI/MTLO. The hazard unit guarantees this never happens; the unit must still be safe if it does.
- MTHI/MTLO with start=1, busy=0: hi (or lo) <= a at that edge. busy stays 0. Single-cycle.
- md_op=NONE with start=1: no effect. start=0: no effect regardless of md_op.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned.
- Boundaries:
  - Divide by zero (b=0, DIV or DIVU): full DIV_CYCLES busy period runs, but hi/lo are left unchanged at completion.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - Back-to-back issue: a start on the cycle busy falls (edge N+L+1) is accepted normally.
- Implementation freedom: the result may be computed at issue (combinational * and /) or iteratively. The externally visible latency must match exactly L.

Decomposition:
- Shared package (cpu_defs): md_op encodings MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6. The same constants are used by the decoder and the hazard unit.
- Sub-modules: none. The counter and pending registers live inline.

Test Plan:
1. MULT a=0xFFFFFFFF, b=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat as MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> busy exactly 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. Preset hi=0x11, lo=0x22 via MTHI/MTLO, then DIV a=5, b=0 -> busy 10 cycles; hi=0x11, lo=0x22 afterward. md_out follows rd_hi.
4. MULT 3*4 issued, MTHI a=0xDEAD at busy cycle 2 -> MTHI ignored; final hi=0, lo=12.
5. DIV issued, reset asserted during busy cycle 3 -> next cycle busy=0, hi=lo=0; no later commit of the abandoned result.
6. MULT completes; new start on the first cycle busy is low -> accepted; busy re-asserts for the full latency. Separately, start with md_op=NONE -> no state change.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared core definitions: md_op encodings used by the decoder, hazard unit and md_unit.
package cpu_defs;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

endpackage

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding HI/LO; results are computed at issue and
// committed after a fixed busy period so the hazard unit sees a deterministic latency.
module md_unit
    import cpu_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            rd_hi,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_op_e op;
    assign op = md_op_e'(md_op);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]  pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_ok_q, pend_ok_d;

    // One shared multiplier: sign-extending to 64 bits makes the low 64 product bits
    // correct for both signed and unsigned operands.
    logic            mul_signed;
    logic [63:0]     mul_a, mul_b, product;
    assign mul_signed = (op == MD_MULT);
    assign mul_a      = {{32{mul_signed & a[31]}}, a};
    assign mul_b      = {{32{mul_signed & b[31]}}, b};
    assign product    = mul_a * mul_b;

    // Signed division runs on magnitudes; 0x80000000 / -1 then wraps to 0x80000000.
    logic            div_signed, neg_q, neg_r;
    logic [XLEN-1:0] div_a, div_b, uq, ur, quot, rem;
    assign div_signed = (op == MD_DIV);
    assign neg_q      = div_signed & (a[31] ^ b[31]);
    assign neg_r      = div_signed & a[31];
    assign div_a      = (div_signed & a[31]) ? -a : a;
    assign div_b      = (div_signed & b[31]) ? -b : b;
    assign uq         = (div_b == '0) ? '0 : div_a / div_b;
    assign ur         = (div_b == '0) ? '0 : div_a % div_b;
    assign quot       = neg_q ? -uq : uq;
    assign rem        = neg_r ? -ur : ur;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;

        if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                if (pend_ok_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (start) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    pend_hi_d = product[63:32];
                    pend_lo_d = product[31:0];
                    pend_ok_d = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    // Divide by zero still occupies the unit but leaves HI/LO untouched.
                    pend_ok_d = (b != '0);
                end
                MD_MTHI: hi_d = a;
                MD_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values; reset is synchronous and abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a reference model pushes expected HI/LO and latency
// into a scoreboard at issue, and entries are popped when busy falls.
module tb_md_unit;
    import cpu_defs::*;

    localparam int MULT_L = 5;
    localparam int DIV_L  = 10;

    logic        clk = 1'b0;
    logic        reset, start, rd_hi;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, md_out;

    md_unit #(.MULT_CYCLES(MULT_L), .DIV_CYCLES(DIV_L)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .rd_hi(rd_hi), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_hi, mdl_lo;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".hi"}, hi, mdl_hi);
        check({tag, ".lo"}, lo, mdl_lo);
        rd_hi = 1'b1; #1;
        check({tag, ".md_out_hi"}, md_out, mdl_hi);
        rd_hi = 1'b0; #1;
        check({tag, ".md_out_lo"}, md_out, mdl_lo);
    endtask

    // Drives one start pulse; when accept is set the model is updated as the DUT should be.
    task automatic issue(input md_op_e op, input logic [31:0] av, input logic [31:0] bv,
                         input bit accept);
        exp_t        e;
        longint      la, lb, q, r;
        logic [63:0] p;
        start = 1'b1; md_op = op; a = av; b = bv;
        if (accept) begin
            e.hi = mdl_hi; e.lo = mdl_lo;
            case (op)
                MD_MULT: begin
                    p = 64'(longint'($signed(av)) * longint'($signed(bv)));
                    e.lat = MULT_L; e.hi = p[63:32]; e.lo = p[31:0]; sb.push_back(e);
                end
                MD_MULTU: begin
                    p = {32'b0, av} * {32'b0, bv};
                    e.lat = MULT_L; e.hi = p[63:32]; e.lo = p[31:0]; sb.push_back(e);
                end
                MD_DIV, MD_DIVU: begin
                    e.lat = DIV_L;
                    if (bv != 32'd0) begin
                        la = (op == MD_DIV) ? longint'($signed(av)) : longint'({32'b0, av});
                        lb = (op == MD_DIV) ? longint'($signed(bv)) : longint'({32'b0, bv});
                        q = la / lb;
                        r = la % lb;
                        e.lo = q[31:0];
                        e.hi = r[31:0];
                    end
                    sb.push_back(e);
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        if (accept && op == MD_MTHI) mdl_hi = av;
        if (accept && op == MD_MTLO) mdl_lo = av;
        start = 1'b0; md_op = MD_NONE;
    endtask

    // Counts remaining busy cycles (bounded), then compares against the scoreboard head.
    task automatic wait_done(input string tag, input int already);
        exp_t e;
        int   n = 0;
        forever begin
            @(negedge clk);
            if (!busy || n >= 64) break;
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, 32'(n), 32'(e.lat - already));
        mdl_hi = e.hi;
        mdl_lo = e.lo;
        check_regs(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = '0; b = '0; rd_hi = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check_regs("reset");

        // Multiplies, signed and unsigned
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done("mult_neg", 0);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done("multu", 0);

        // Divides including the signed overflow corner
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div_neg", 0);
        issue(MD_DIVU, 32'd7, 32'd2, 1'b1);
        wait_done("divu", 0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_ovf", 0);

        // MTHI/MTLO then divide by zero leaves them intact
        issue(MD_MTHI, 32'h11, 32'd0, 1'b1);
        @(negedge clk);
        check("mthi.busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0, 1'b1);
        @(negedge clk);
        check_regs("mtlo");
        issue(MD_DIV, 32'd5, 32'd0, 1'b1);
        wait_done("div_zero", 0);

        // Reset during busy cycle 3 abandons the divide
        issue(MD_DIV, 32'd100, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        mdl_hi = '0; mdl_lo = '0;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check_regs("rst_mid");
        repeat (15) @(negedge clk);
        check("rst_late.busy", 32'(busy), 32'd0);
        check_regs("rst_late");

        // MTHI while busy is ignored
        @(negedge clk);
        issue(MD_MULT, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        issue(MD_MTHI, 32'hDEAD, 32'd0, 1'b0);
        wait_done("mthi_busy", 2);

        // Back-to-back: issue on the first cycle busy is low
        issue(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_done("b2b_first", 0);
        issue(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_done("b2b_second", 0);

        // No-ops: start with NONE, and a real op without start
        issue(MD_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        check("none.busy", 32'(busy), 32'd0);
        check_regs("none");
        md_op = MD_MTHI; a = 32'hBEEF; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("nostart.busy", 32'(busy), 32'd0);
        check_regs("nostart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
